except_merge_stage: RTL and testbench
=====================================

# except_merge_stage

Parametrised pipeline-stage exception collector and register. It merges an exception carried in from the previous stage with NUM_SRC locally detected exception sources, such as fetch misalign, access fault, page fault or illegal instruction. The winning exception is registered into the next stage under stall/flush control. After an exception has been registered, an optional shadow FSM squashes younger instructions until the pipeline is flushed. One instance sits at each IF/ID, ID/EX and EX/MEM boundary.

## Interface
Parameters:
- NUM_SRC, 4, number of local exception sources (1..8); index 0 has the highest priority.
- SHADOW_EN, 1, 1 enables the shadow (squash) FSM; 0 makes the block a plain merge register.
- CNT_W, 8, width of the saturating squash counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  hold the output register, FSM state and counter.
- flush  in  1  clear the output register and return the FSM to RUN; has priority over stall.
- valid_i  in  1  an instruction is present in this stage.
- pc_i  in  64  PC of that instruction.
- except_i  in  ExceptPack  exception carried in from the previous stage.
- src_hit_i  in  NUM_SRC  per-source exception request.
- src_cause_i  in  NUM_SRC×64  per-source cause code.
- src_tval_i  in  NUM_SRC×64  per-source trap value.
- valid_o  out  1  registered instruction-valid for the next stage.
- except_o  out  ExceptPack  registered exception for the next stage.
- except_happen_o  out  1  combinational: this stage accepts a new exception this cycle.
- shadow_o  out  1  FSM is in SHADOW.
- squash_cnt_o  out  CNT_W  saturating count of instructions squashed in SHADOW.

## Operation
- Merge (combinational):
  - Inherited wins: if valid_i and except_i.except, the selection is except_i unchanged.
  - Otherwise, if valid_i and any src_hit_i bit is set, the lowest set index k wins: except=1, epc=pc_i, ecause=src_cause_i[k], etval=src_tval_i[k].
  - Otherwise the selection is all-zero.
- FSM states are RUN and SHADOW. If SHADOW_EN=0, the FSM stays in RUN permanently.
  - RUN -> SHADOW: on a cycle with !flush, !stall, and a selection with except=1 (inherited or local).
  - SHADOW -> RUN: only on flush.
  - In SHADOW, the incoming valid_i is treated as 0: valid_o=0, except_o=0, and squash_cnt increments by 1 per valid_i cycle when not stalled. The counter saturates at all-ones.
- except_happen_o = selection.except AND state==RUN AND !flush.
- Register update order, per edge:
  1. !rst: clear everything.
  2. Else flush: valid_o=0, except_o=0, state=RUN. The counter is held, not cleared.
  3. Else stall: hold all state.
  4. Else: load valid_o and except_o from the effective input (squashed in SHADOW).
- The squash counter is cleared only by reset.

## Timing
- Output latency is 1 cycle from the inputs to valid_o/except_o. except_happen_o has zero latency.
- Reset values: valid_o=0, except_o all-zero, shadow_o=0, squash_cnt_o=0, state=RUN.
- flush and a new exception in the same cycle: flush wins. The register clears, the state stays/returns to RUN, and except_happen_o=0.
- stall and a new exception in the same cycle: no capture and no state change. except_happen_o is still 1, so the request remains visible until it is accepted.
- Entry into SHADOW takes effect the cycle after capture. The capturing instruction itself is registered normally.
- If stall is asserted during SHADOW, squash_cnt does not increment.
- Counter at saturation: a further squash leaves the value at 2^CNT_W−1.

## Structure
- Shared package ExceptStruct:
  - ExceptPack {except:1, epc:64, ecause:64, etval:64}.
  - Cause-code constants: INST_MISALIGN, INST_ACCESS_FAULT, ILLEGAL_INST, INST_PAGE_FAULT, LOAD_PAGE_FAULT, STORE_PAGE_FAULT.
  - FSM state enum {RUN, SHADOW}.
- One sub-module is natural: except_prio_sel, a parametrised NUM_SRC fixed-priority selector producing the hit flag, index and the muxed cause/tval.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs → all outputs zero and shadow_o=0 throughout.
- Priority: valid_i=1, pc_i=0x8000_0010, src_hit_i=4'b1010, cause[1]=12, cause[3]=2 → except_happen_o=1 that cycle. Next cycle except_o={1,0x8000_0010,12,tval[1]}.
- Inherited wins: except_i={1,0x100,13,0x200} with src_hit_i=4'b0001 → except_o equals except_i exactly, not src 0.
- Shadow: capture an exception, then 3 valid instructions with no flush → valid_o=0 for those 3, squash_cnt_o=3, shadow_o=1. Flush → shadow_o=0 and the next clean instruction passes with valid_o=1.
- Stall/flush collision: exception with stall=1 for 2 cycles → outputs held, shadow_o=0. Then stall=1 and flush=1 together → register cleared and state RUN.
- Saturation with CNT_W=2: 5 squashed instructions → squash_cnt_o=3. With SHADOW_EN=0, back-to-back exceptions are all registered and shadow_o=0.

Source files
------------

// File: rtl/except_merge_stage_pkg.sv
// Shared exception types, cause codes and shadow FSM state for the merge stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ExceptStruct;

   // Exception record carried down the pipeline with each instruction
   typedef struct packed {
      logic        except;
      logic [63:0] epc;
      logic [63:0] ecause;
      logic [63:0] etval;
   } ExceptPack;

   // Cause codes for the locally detected sources
   localparam logic [63:0] INST_MISALIGN     = 64'd0;
   localparam logic [63:0] INST_ACCESS_FAULT = 64'd1;
   localparam logic [63:0] ILLEGAL_INST      = 64'd2;
   localparam logic [63:0] INST_PAGE_FAULT   = 64'd12;
   localparam logic [63:0] LOAD_PAGE_FAULT   = 64'd13;
   localparam logic [63:0] STORE_PAGE_FAULT  = 64'd15;

   // Shadow FSM: RUN passes instructions, SHADOW squashes them until a flush
   typedef enum logic {
      RUN    = 1'b0,
      SHADOW = 1'b1
   } shadow_state_e;

endpackage

// File: rtl/except_merge_stage_prio_sel.sv
// Fixed-priority selector over the local exception sources; index 0 wins.
// Latency: purely combinational.
// Backpressure: none, outputs follow the inputs directly.
module except_prio_sel #(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0]       hit_i,
   input  logic [NUM_SRC-1:0][63:0] cause_i,
   input  logic [NUM_SRC-1:0][63:0] tval_i,
   output logic                     hit_o,
   output logic [IDX_W-1:0]         idx_o,
   output logic [63:0]              cause_o,
   output logic [63:0]              tval_o
);

   // Scan from the lowest priority upward so the lowest set index is the final assignment
   always_comb begin
      hit_o   = 1'b0;
      idx_o   = '0;
      cause_o = '0;
      tval_o  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (hit_i[i]) begin
            hit_o   = 1'b1;
            idx_o   = IDX_W'(i);
            cause_o = cause_i[i];
            tval_o  = tval_i[i];
         end
      end
   end

endmodule

// File: rtl/except_merge_stage.sv
// Merges the inherited exception with local sources and registers the winner; shadow FSM squashes younger instrs.
// Latency: 1 cycle to valid_o/except_o; except_happen_o is combinational.
// Backpressure: stall holds register, FSM and counter; flush clears the register and beats stall.
import ExceptStruct::*;

module except_merge_stage #(
   parameter int NUM_SRC   = 4,
   parameter int SHADOW_EN = 1,
   parameter int CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     valid_i,
   input  logic [63:0]              pc_i,
   input  ExceptPack                except_i,
   input  logic [NUM_SRC-1:0]       src_hit_i,
   input  logic [NUM_SRC-1:0][63:0] src_cause_i,
   input  logic [NUM_SRC-1:0][63:0] src_tval_i,
   output logic                     valid_o,
   output ExceptPack                except_o,
   output logic                     except_happen_o,
   output logic                     shadow_o,
   output logic [CNT_W-1:0]         squash_cnt_o
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic               loc_hit;
   logic [IDX_W-1:0]   loc_idx;
   logic [63:0]        loc_cause;
   logic [63:0]        loc_tval;
   ExceptPack          sel;
   logic               eff_valid;
   ExceptPack          eff_except;
   shadow_state_e      state_q, state_d;
   logic               valid_q;
   ExceptPack          except_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   except_prio_sel #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_prio_sel (
      .hit_i   (src_hit_i),
      .cause_i (src_cause_i),
      .tval_i  (src_tval_i),
      .hit_o   (loc_hit),
      .idx_o   (loc_idx),
      .cause_o (loc_cause),
      .tval_o  (loc_tval)
   );

   // The selected index must always point at a requesting source
   a_idx_consistent : assert property (@(posedge clk) disable iff (!rst)
      loc_hit |-> src_hit_i[loc_idx]);

   // Merge: an exception inherited from upstream is older and always wins over local ones
   always_comb begin
      sel = '0;
      if (valid_i && except_i.except) begin
         sel = except_i;
      end else if (valid_i && loc_hit) begin
         sel.except = 1'b1;
         sel.epc    = pc_i;
         sel.ecause = loc_cause;
         sel.etval  = loc_tval;
      end
   end

   // Effective input: in SHADOW the instruction is squashed before it reaches the register
   always_comb begin
      eff_valid  = valid_i && (state_q == RUN);
      eff_except = (state_q == RUN) ? sel : '0;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: enter SHADOW only on an accepted capture, leave only on flush
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = RUN;
      end else if (!stall && (state_q == RUN) && sel.except && (SHADOW_EN != 0)) begin
         state_d = SHADOW;
      end
   end

   // FSM outputs: the request stays visible while stalled but is withdrawn by a flush
   always_comb begin
      shadow_o        = (state_q == SHADOW);
      except_happen_o = sel.except && (state_q == RUN) && !flush;
   end

   // Stage register for the next pipeline stage
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q  <= 1'b0;
         except_q <= '0;
      end else if (flush) begin
         valid_q  <= 1'b0;
         except_q <= '0;
      end else if (!stall) begin
         valid_q  <= eff_valid;
         except_q <= eff_except;
      end
   end

   // Squash counter next value: counts squashed instructions, sticks at all-ones, survives flush
   always_comb begin
      cnt_d = cnt_q;
      if (!flush && !stall && (state_q == SHADOW) && valid_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Squash counter register, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign valid_o      = valid_q;
   assign except_o     = except_q;
   assign squash_cnt_o = cnt_q;

endmodule

// File: tb/tb_except_merge_stage.sv
// Bench for except_merge_stage: three instances (default, CNT_W=2, SHADOW_EN=0) share one stimulus.
// Latency: checks registered outputs 1 ns after each rising edge, except_happen_o before the edge.
// Backpressure: stall/flush driven by directed sequences and randomly.
import ExceptStruct::*;

module tb_except_merge_stage;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall, flush, valid_i;
   logic [63:0]       pc_i;
   ExceptPack         except_i;
   logic [3:0]        src_hit_i;
   logic [3:0][63:0]  src_cause_i;
   logic [3:0][63:0]  src_tval_i;

   logic       main_valid, sat_valid, ns_valid;
   ExceptPack  main_exc, sat_exc, ns_exc;
   logic       main_hap, sat_hap, ns_hap;
   logic       main_sh, sat_sh, ns_sh;
   logic [7:0] main_cnt, ns_cnt;
   logic [1:0] sat_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   except_merge_stage #(.NUM_SRC(4), .SHADOW_EN(1), .CNT_W(8)) dut_main (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i), .pc_i(pc_i),
      .except_i(except_i), .src_hit_i(src_hit_i), .src_cause_i(src_cause_i), .src_tval_i(src_tval_i),
      .valid_o(main_valid), .except_o(main_exc), .except_happen_o(main_hap),
      .shadow_o(main_sh), .squash_cnt_o(main_cnt));

   except_merge_stage #(.NUM_SRC(4), .SHADOW_EN(1), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i), .pc_i(pc_i),
      .except_i(except_i), .src_hit_i(src_hit_i), .src_cause_i(src_cause_i), .src_tval_i(src_tval_i),
      .valid_o(sat_valid), .except_o(sat_exc), .except_happen_o(sat_hap),
      .shadow_o(sat_sh), .squash_cnt_o(sat_cnt));

   except_merge_stage #(.NUM_SRC(4), .SHADOW_EN(0), .CNT_W(8)) dut_ns (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i), .pc_i(pc_i),
      .except_i(except_i), .src_hit_i(src_hit_i), .src_cause_i(src_cause_i), .src_tval_i(src_tval_i),
      .valid_o(ns_valid), .except_o(ns_exc), .except_happen_o(ns_hap),
      .shadow_o(ns_sh), .squash_cnt_o(ns_cnt));

   // Reference model, one slot per instance: 0 = main, 1 = sat, 2 = no-shadow
   logic      m_vld [3];
   ExceptPack m_exc [3];
   logic      m_sh  [3];
   int        m_cnt [3];
   int        cmax  [3] = '{255, 3, 255};
   bit        sen   [3] = '{1'b1, 1'b1, 1'b0};

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Specification-level merge: older inherited exception first, else first requesting source
   function automatic ExceptPack sel_model();
      ExceptPack s = '0;
      if (valid_i && except_i.except) begin
         s = except_i;
      end else if (valid_i && src_hit_i != 4'b0) begin
         int k = 0;
         while (!src_hit_i[k]) k++;
         s = '{1'b1, pc_i, src_cause_i[k], src_tval_i[k]};
      end
      return s;
   endfunction

   function automatic void model_edge();
      ExceptPack s = sel_model();
      for (int m = 0; m < 3; m++) begin
         if (!rst) begin
            m_vld[m] = 1'b0; m_exc[m] = '0; m_sh[m] = 1'b0; m_cnt[m] = 0;
         end else if (flush) begin
            m_vld[m] = 1'b0; m_exc[m] = '0; m_sh[m] = 1'b0;
         end else if (!stall) begin
            if (m_sh[m]) begin
               m_vld[m] = 1'b0; m_exc[m] = '0;
               if (valid_i && m_cnt[m] < cmax[m]) m_cnt[m] = m_cnt[m] + 1;
            end else begin
               m_vld[m] = valid_i; m_exc[m] = s;
               if (s.except && sen[m]) m_sh[m] = 1'b1;
            end
         end
      end
   endfunction

   task automatic check_happen();
      ExceptPack s = sel_model();
      chk("happen_main", main_hap, s.except && !m_sh[0] && !flush);
      chk("happen_sat",  sat_hap,  s.except && !m_sh[1] && !flush);
      chk("happen_ns",   ns_hap,   s.except && !m_sh[2] && !flush);
   endtask

   task automatic check_regs();
      chk("valid_main", main_valid, m_vld[0]);
      chk("exc_main",   main_exc,   m_exc[0]);
      chk("shadow_main", main_sh,   m_sh[0]);
      chk("cnt_main",   main_cnt,   m_cnt[0]);
      chk("valid_sat",  sat_valid,  m_vld[1]);
      chk("exc_sat",    sat_exc,    m_exc[1]);
      chk("shadow_sat", sat_sh,     m_sh[1]);
      chk("cnt_sat",    sat_cnt,    m_cnt[1]);
      chk("valid_ns",   ns_valid,   m_vld[2]);
      chk("exc_ns",     ns_exc,     m_exc[2]);
      chk("shadow_ns",  ns_sh,      m_sh[2]);
      chk("cnt_ns",     ns_cnt,     m_cnt[2]);
   endtask

   // One clock: check combinational request, advance the edge, check registers against the model
   task automatic tick(input bit do_hap);
      #1;
      if (do_hap) check_happen();
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
   endtask

   task automatic clear_in();
      stall = 0; flush = 0; valid_i = 0; pc_i = '0; except_i = '0; src_hit_i = '0;
      src_cause_i[0] = INST_ACCESS_FAULT; src_cause_i[1] = INST_PAGE_FAULT;
      src_cause_i[2] = INST_MISALIGN;     src_cause_i[3] = ILLEGAL_INST;
      for (int k = 0; k < 4; k++) src_tval_i[k] = 64'h1000 + 64'(k);
   endtask

   task automatic rand_in();
      valid_i = ($urandom_range(3) != 0);
      pc_i = {$urandom, $urandom};
      except_i = '{($urandom_range(7) == 0), {$urandom, $urandom}, 64'($urandom_range(15)), {$urandom, $urandom}};
      src_hit_i = ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0;
      for (int k = 0; k < 4; k++) begin
         src_cause_i[k] = 64'($urandom_range(15));
         src_tval_i[k]  = {$urandom, $urandom};
      end
      stall = ($urandom_range(5) == 0);
      flush = ($urandom_range(9) == 0);
   endtask

   typedef struct {
      logic       valid;
      logic [63:0] pc;
      ExceptPack  exc_in;
      logic [3:0] hit;
      logic       exp_hap;
      ExceptPack  exp_exc;
   } vec_t;

   vec_t vecs [7];

   initial begin
      for (int m = 0; m < 3; m++) begin
         m_vld[m] = 0; m_exc[m] = '0; m_sh[m] = 0; m_cnt[m] = 0;
      end

      // Reset with random inputs: everything clear, no shadow
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rand_in();
         tick(1'b0);
         chk("rst_valid", main_valid, 1'b0);
         chk("rst_exc", main_exc, '0);
         chk("rst_shadow", main_sh, 1'b0);
         chk("rst_cnt", main_cnt, 8'd0);
      end
      rst = 1'b1;
      clear_in();
      tick(1'b1);

      // Shadow entry, three squashed instructions, flush, clean instruction
      valid_i = 1; pc_i = 64'h200; src_hit_i = 4'b0001;
      #1 chk("shd_happen", main_hap, 1'b1);
      tick(1'b1);
      chk("shd_cap_valid", main_valid, 1'b1);
      chk("shd_cap_exc", main_exc, {1'b1, 64'h200, INST_ACCESS_FAULT, 64'h1000});
      chk("shd_enter", main_sh, 1'b1);
      src_hit_i = 4'b0;
      for (int i = 0; i < 3; i++) begin
         pc_i = 64'h204 + 64'(4 * i);
         tick(1'b1);
         chk("shd_squash_valid", main_valid, 1'b0);
      end
      chk("shd_cnt3", main_cnt, 8'd3);
      chk("shd_still", main_sh, 1'b1);
      valid_i = 0; flush = 1;
      tick(1'b1);
      chk("shd_flush_exit", main_sh, 1'b0);
      chk("shd_flush_cnt_held", main_cnt, 8'd3);
      flush = 0; valid_i = 1; pc_i = 64'h300;
      tick(1'b1);
      chk("shd_clean_valid", main_valid, 1'b1);
      chk("shd_clean_exc", main_exc.except, 1'b0);

      // Stall/flush collision
      pc_i = 64'h400; src_hit_i = 4'b0100; stall = 1;
      for (int i = 0; i < 2; i++) begin
         #1 chk("col_happen_stall", main_hap, 1'b1);
         tick(1'b1);
         chk("col_hold_valid", main_valid, 1'b1);
         chk("col_hold_exc", main_exc.except, 1'b0);
         chk("col_no_shadow", main_sh, 1'b0);
      end
      flush = 1;
      #1 chk("col_happen_flush", main_hap, 1'b0);
      tick(1'b1);
      chk("col_clr_valid", main_valid, 1'b0);
      chk("col_clr_shadow", main_sh, 1'b0);
      stall = 0; flush = 0;
      tick(1'b1);
      chk("col_capture", main_exc, {1'b1, 64'h400, INST_MISALIGN, 64'h1002});
      valid_i = 0; src_hit_i = 4'b0; flush = 1;
      tick(1'b1);
      flush = 0;

      // Back-to-back exceptions: no-shadow registers all, counters squash the rest
      for (int i = 0; i < 3; i++) begin
         valid_i = 1; pc_i = 64'h500 + 64'(4 * i); src_hit_i = 4'b0001;
         tick(1'b1);
         chk("ns_b2b_valid", ns_valid, 1'b1);
         chk("ns_b2b_epc", ns_exc.epc, 64'h500 + 64'(4 * i));
         chk("ns_b2b_shadow", ns_sh, 1'b0);
      end
      src_hit_i = 4'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1);
         chk("sat_hold", sat_cnt, 2'd3);
      end
      chk("main_cnt8", main_cnt, 8'd8);
      valid_i = 0; flush = 1;
      tick(1'b1);
      flush = 0;

      // Merge table on the no-shadow instance
      vecs[0] = '{1'b1, 64'h8000_0010, '0, 4'b1010, 1'b1, '{1'b1, 64'h8000_0010, 64'd12, 64'h1001}};
      vecs[1] = '{1'b1, 64'h40, '{1'b1, 64'h100, 64'd13, 64'h200}, 4'b0001, 1'b1, '{1'b1, 64'h100, 64'd13, 64'h200}};
      vecs[2] = '{1'b0, 64'h44, '{1'b1, 64'h100, 64'd13, 64'h200}, 4'b1111, 1'b0, '0};
      vecs[3] = '{1'b1, 64'h48, '0, 4'b0000, 1'b0, '0};
      vecs[4] = '{1'b1, 64'h4c, '0, 4'b1000, 1'b1, '{1'b1, 64'h4c, 64'd2, 64'h1003}};
      vecs[5] = '{1'b1, 64'h50, '0, 4'b0100, 1'b1, '{1'b1, 64'h50, 64'd0, 64'h1002}};
      vecs[6] = '{1'b1, 64'h54, '{1'b0, 64'h999, 64'd5, 64'd6}, 4'b0000, 1'b0, '0};
      for (int i = 0; i < 7; i++) begin
         valid_i = vecs[i].valid; pc_i = vecs[i].pc; except_i = vecs[i].exc_in; src_hit_i = vecs[i].hit;
         #1 chk("tbl_happen", ns_hap, vecs[i].exp_hap);
         tick(1'b1);
         chk("tbl_valid", ns_valid, vecs[i].valid);
         chk("tbl_exc", ns_exc, vecs[i].exp_exc);
      end

      // Randomized run against the model, with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rand_in();
         rst = ($urandom_range(299) != 0);
         tick(1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
